imm_gen_pipe: RTL and testbench

Parametrised, pipelined immediate generator for the RISC-V datapath, sitting between instruction fetch/decode and the ALU/branch unit. It decodes the immediate of every base-ISA format (I, S, B, U, J, shift-amount), sign- or zero-extends it to XLEN, and precomputes the PC-relative target. It flags unsupported opcodes. Results are registered behind a valid/ready handshake with an optional skid buffer, so the block can sit in a stallable decode stage.

---
 rtl/imm_gen_pkg.sv | 20 ++
 rtl/imm_gen_pipe_decode.sv | 38 +++
 rtl/imm_gen_pipe.sv | 84 ++++++++
 tb/tb_imm_gen_pipe.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared format codes and base-ISA opcodes for the immediate generator
package imm_gen_pkg;
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6
  } fmt_t;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
endpackage

// File: rtl/imm_gen_pipe_decode.sv
// imm_decode: combinational immediate decode, extension and pc-relative target
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] imm,
  output fmt_t            fmt,
  output logic [XLEN-1:0] target,
  output logic            illegal
);
  logic [6:0]  opc;
  logic        s;
  logic [31:0] raw;
  logic [5:0]  shamt;
  always_comb begin
    opc = inst[6:0];
    s   = inst[31];
    fmt = opc == OPC_OPIMM ? (inst[13:12] == 2'b01 ? FMT_SH : FMT_I) :
          (opc == OPC_LOAD || opc == OPC_JALR) ? FMT_I :
          opc == OPC_STORE ? FMT_S :
          opc == OPC_BRANCH ? FMT_B :
          (opc == OPC_LUI || opc == OPC_AUIPC) ? FMT_U :
          opc == OPC_JAL ? FMT_J : FMT_NONE;
    raw = fmt == FMT_I ? {{20{s}}, inst[31:20]} :
          fmt == FMT_S ? {{20{s}}, inst[31:25], inst[11:7]} :
          fmt == FMT_B ? {{19{s}}, s, inst[7], inst[30:25], inst[11:8], 1'b0} :
          fmt == FMT_U ? {inst[31:12], 12'b0} :
          fmt == FMT_J ? {{11{s}}, s, inst[19:12], inst[20], inst[30:21], 1'b0} : 32'b0;
    // bit 5 of the shift amount only exists on RV64
    shamt   = {XLEN == 64 && inst[25], inst[24:20]};
    imm     = fmt == FMT_SH ? XLEN'(shamt) : XLEN'($signed(raw));
    target  = pc + imm;
    illegal = fmt == FMT_NONE;
  end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator behind a valid/ready handshake with optional skid buffer
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic [XLEN-1:0] target_o,
  output logic            illegal_o
);
  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_t            fmt;
    logic [XLEN-1:0] target;
    logic            illegal;
  } bundle_t;
  bundle_t         dec, main_q;
  logic            main_v, in_xfer, out_xfer;
  logic [XLEN-1:0] d_imm, d_tgt;
  fmt_t            d_fmt;
  logic            d_ill;
  imm_decode #(.XLEN(XLEN)) u_dec (
    .inst    (inst_i),
    .pc      (pc_i),
    .imm     (d_imm),
    .fmt     (d_fmt),
    .target  (d_tgt),
    .illegal (d_ill)
  );
  assign dec       = {d_imm, d_fmt, d_tgt, d_ill};
  assign in_xfer   = valid_i && ready_o;
  assign out_xfer  = valid_o && ready_i;
  assign valid_o   = main_v;
  assign imm_o     = main_q.imm;
  assign fmt_o     = main_q.fmt;
  assign target_o  = main_q.target;
  assign illegal_o = main_q.illegal;
  if (SKID != 0) begin : g_skid
    bundle_t skid_q;
    logic    skid_v, skid_v_n, ready_q;
    // ready_q never admits an input while the skid holds data
    assign skid_v_n = skid_v ? !out_xfer : in_xfer && main_v && !out_xfer;
    assign ready_o  = ready_q;
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        main_q  <= '0;
        skid_q  <= '0;
        main_v  <= 1'b0;
        skid_v  <= 1'b0;
        ready_q <= 1'b0;
      end else begin
        if (out_xfer && skid_v) main_q <= skid_q;
        else if (in_xfer && (!main_v || out_xfer)) main_q <= dec;
        if (in_xfer && main_v && !out_xfer) skid_q <= dec;
        main_v  <= skid_v || in_xfer || (main_v && !out_xfer);
        skid_v  <= skid_v_n;
        ready_q <= !skid_v_n;
      end
    end
  end else begin : g_flat
    assign ready_o = rst_ni && (!main_v || ready_i);
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        main_q <= '0;
        main_v <= 1'b0;
      end else if (in_xfer) begin
        main_q <= dec;
        main_v <= 1'b1;
      end else if (out_xfer) begin
        main_v <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed and random checks of a 32-bit skid instance and a 64-bit flat instance
module tb_imm_gen_pipe;
  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [63:0] tgt;
    logic        ill;
  } exp_t;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        a_vi, a_ro, a_vo, a_ri, a_ill;
  logic [31:0] a_inst, a_pc, a_imm, a_tgt;
  logic [2:0]  a_fmt;
  logic        b_vi, b_ro, b_vo, b_ri, b_ill;
  logic [31:0] b_inst;
  logic [63:0] b_pc, b_imm, b_tgt;
  logic [2:0]  b_fmt;
  int          n_vec = 0, n_err = 0;
  exp_t        q[2][$];
  exp_t        held[2];
  bit          stall[2];
  localparam logic [31:0] TA_INST [5] = '{32'hFFF00093, 32'hFE000EE3, 32'h0000006F, 32'h0000007F, 32'h00000000};
  localparam logic [31:0] TA_PC   [5] = '{32'h100, 32'h1000, 32'h200, 32'h300, 32'h400};
  localparam logic [31:0] TA_IMM  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h0};
  localparam logic [2:0]  TA_FMT  [5] = '{3'd1, 3'd3, 3'd5, 3'd0, 3'd0};
  localparam logic [31:0] TA_TGT  [5] = '{32'hFF, 32'hFFC, 32'h200, 32'h300, 32'h400};
  localparam logic        TA_ILL  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic [31:0] TB_INST [5] = '{32'h800000B7, 32'h03F09093, 32'hFFF00093, 32'h0000007F, 32'h00001017};
  localparam logic [63:0] TB_PC   [5] = '{64'h0, 64'h40, 64'h100, 64'h10, 64'h1000};
  localparam logic [63:0] TB_IMM  [5] = '{64'hFFFFFFFF80000000, 64'h3F, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h1000};
  localparam logic [2:0]  TB_FMT  [5] = '{3'd4, 3'd6, 3'd1, 3'd0, 3'd4};
  localparam logic [63:0] TB_TGT  [5] = '{64'hFFFFFFFF80000000, 64'h7F, 64'hFF, 64'h10, 64'h2000};
  localparam logic        TB_ILL  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .SKID(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(a_vi), .ready_o(a_ro), .inst_i(a_inst), .pc_i(a_pc),
    .valid_o(a_vo), .ready_i(a_ri), .imm_o(a_imm), .fmt_o(a_fmt), .target_o(a_tgt), .illegal_o(a_ill)
  );
  imm_gen_pipe #(.XLEN(64), .SKID(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(b_vi), .ready_o(b_ro), .inst_i(b_inst), .pc_i(b_pc),
    .valid_o(b_vo), .ready_i(b_ri), .imm_o(b_imm), .fmt_o(b_fmt), .target_o(b_tgt), .illegal_o(b_ill)
  );

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sx(logic [63:0] v, int w);
    return ((v >> (w - 1)) & 64'd1) != 0 ? v - (64'd1 << w) : v;
  endfunction

  function automatic exp_t model(logic [31:0] inst, logic [63:0] pc, int xlen);
    exp_t        e;
    logic [63:0] m;
    m = xlen == 64 ? '1 : 64'hFFFF_FFFF;
    e.imm = 64'd0;
    e.fmt = 3'd0;
    case (inst[6:0])
      7'h13: if (inst[14:12] == 3'd1 || inst[14:12] == 3'd5) begin
        e.fmt = 3'd6;
        e.imm = xlen == 64 ? 64'(inst[25:20]) : 64'(inst[24:20]);
      end else begin
        e.fmt = 3'd1;
        e.imm = sx(64'(inst[31:20]), 12);
      end
      7'h03, 7'h67: begin e.fmt = 3'd1; e.imm = sx(64'(inst[31:20]), 12); end
      7'h23: begin e.fmt = 3'd2; e.imm = sx(64'(inst[31:25]) * 32 + 64'(inst[11:7]), 12); end
      7'h63: begin
        e.fmt = 3'd3;
        e.imm = sx(64'(inst[31]) * 4096 + 64'(inst[7]) * 2048 + 64'(inst[30:25]) * 32 + 64'(inst[11:8]) * 2, 13);
      end
      7'h37, 7'h17: begin e.fmt = 3'd4; e.imm = sx(64'(inst[31:12]) * 4096, 32); end
      7'h6F: begin
        e.fmt = 3'd5;
        e.imm = sx(64'(inst[31]) * (64'd1 << 20) + 64'(inst[19:12]) * 4096 + 64'(inst[20]) * 2048 + 64'(inst[30:21]) * 2, 21);
      end
      default: ;
    endcase
    e.imm = e.imm & m;
    e.tgt = (pc + e.imm) & m;
    e.ill = e.fmt == 3'd0;
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom();
    case ($urandom_range(0, 8))
      0: op = 7'h13;
      1: op = 7'h03;
      2: op = 7'h67;
      3: op = 7'h23;
      4: op = 7'h63;
      5: op = 7'h37;
      6: op = 7'h17;
      7: op = 7'h6F;
      default: op = r[6:0];
    endcase
    return {r[31:7], op};
  endfunction

  task automatic score(int s, logic vi, logic ro, logic [31:0] inst, logic [63:0] pc, logic vo, logic ri,
                       logic [63:0] imm, logic [2:0] fmt, logic [63:0] tgt, logic ill);
    int    occ;
    exp_t  e;
    string p;
    occ = q[s].size();
    p   = s == 0 ? "x32" : "x64";
    check({p, " valid_o"}, 64'(vo), 64'(occ > 0));
    check({p, " ready_o"}, 64'(ro), s == 0 ? 64'(occ < 2) : 64'(occ == 0 || ri));
    if (stall[s]) begin
      check({p, " hold imm"}, imm, held[s].imm);
      check({p, " hold fmt"}, 64'(fmt), 64'(held[s].fmt));
      check({p, " hold target"}, tgt, held[s].tgt);
      check({p, " hold illegal"}, 64'(ill), 64'(held[s].ill));
    end
    if (vo && ri && occ > 0) begin
      e = q[s].pop_front();
      check({p, " imm"}, imm, e.imm);
      check({p, " fmt"}, 64'(fmt), 64'(e.fmt));
      check({p, " target"}, tgt, e.tgt);
      check({p, " illegal"}, 64'(ill), 64'(e.ill));
    end
    if (vi && ro) q[s].push_back(model(inst, pc, s == 0 ? 32 : 64));
    stall[s] = vo && !ri;
    held[s]  = '{imm, fmt, tgt, ill};
  endtask

  task automatic step(logic avi, logic ari, logic bvi, logic bri);
    a_vi = avi; a_ri = ari; a_inst = rand_inst(); a_pc = $urandom();
    b_vi = bvi; b_ri = bri; b_inst = rand_inst(); b_pc = {$urandom(), $urandom()};
    #1;
    score(0, a_vi, a_ro, a_inst, 64'(a_pc), a_vo, a_ri, 64'(a_imm), a_fmt, 64'(a_tgt), a_ill);
    score(1, b_vi, b_ro, b_inst, b_pc, b_vo, b_ri, b_imm, b_fmt, b_tgt, b_ill);
    @(negedge clk);
  endtask

  initial begin
    a_vi = 0; a_ri = 0; a_inst = 0; a_pc = 0;
    b_vi = 0; b_ri = 0; b_inst = 0; b_pc = 0;
    repeat (2) @(negedge clk);
    check("reset valid x32", 64'(a_vo), 64'd0);
    check("reset ready x32", 64'(a_ro), 64'd0);
    check("reset valid x64", 64'(b_vo), 64'd0);
    check("reset ready x64", 64'(b_ro), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("release ready x32", 64'(a_ro), 64'd1);
    check("release ready x64", 64'(b_ro), 64'd1);
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) begin
        check("dir32 imm", 64'(a_imm), 64'(TA_IMM[i-1]));
        check("dir32 fmt", 64'(a_fmt), 64'(TA_FMT[i-1]));
        check("dir32 target", 64'(a_tgt), 64'(TA_TGT[i-1]));
        check("dir32 illegal", 64'(a_ill), 64'(TA_ILL[i-1]));
        check("dir64 imm", b_imm, TB_IMM[i-1]);
        check("dir64 fmt", 64'(b_fmt), 64'(TB_FMT[i-1]));
        check("dir64 target", b_tgt, TB_TGT[i-1]);
        check("dir64 illegal", 64'(b_ill), 64'(TB_ILL[i-1]));
      end
      a_ri = 1; b_ri = 1;
      a_vi = i < 5; b_vi = i < 5;
      if (i < 5) begin
        a_inst = TA_INST[i]; a_pc = TA_PC[i];
        b_inst = TB_INST[i]; b_pc = TB_PC[i];
      end
      @(negedge clk);
    end
    for (int c = 0; c < 400; c++) begin
      if (c < 8) step(1'b1, c % 4 == 0 || c % 4 == 3, 1'b1, c % 4 == 0 || c % 4 == 3);
      else if (c < 380) step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                             $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      else step(1'b0, 1'b1, 1'b0, 1'b1);
    end
    check("drain x32", 64'(q[0].size()), 64'd0);
    check("drain x64", 64'(q[1].size()), 64'd0);
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst valid x32", 64'(a_vo), 64'd0);
    check("midrst ready x32", 64'(a_ro), 64'd0);
    check("midrst imm x32", 64'(a_imm), 64'd0);
    check("midrst fmt x32", 64'(a_fmt), 64'd0);
    check("midrst target x32", 64'(a_tgt), 64'd0);
    check("midrst illegal x32", 64'(a_ill), 64'd0);
    check("midrst valid x64", 64'(b_vo), 64'd0);
    check("midrst imm x64", b_imm, 64'd0);
    check("midrst target x64", b_tgt, 64'd0);
    rst_n = 1'b1;
    a_vi = 0; b_vi = 0;
    q[0].delete(); q[1].delete();
    stall[0] = 0; stall[1] = 0;
    @(negedge clk);
    check("post rst ready x32", 64'(a_ro), 64'd1);
    check("post rst valid x32", 64'(a_vo), 64'd0);
    check("post rst ready x64", 64'(b_ro), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
